// File: rtl/lif_pkg.sv
// Shared constants and helpers for the LIF neuron layer.
// Defaults for width, leak, coupling and refractory length; W+2 sum width; saturating clamp.
package lif_pkg;

    localparam int LIF_W          = 8;
    localparam int LIF_LEAK_SHIFT = 1;
    localparam int LIF_COUPLE_W   = 64;
    localparam int LIF_REFRAC     = 2;

    // Two guard bits hold current + coupling + leaked state without wrapping.
    function automatic int sum_width(input int w);
        return w + 2;
    endfunction

    function automatic logic [31:0] sat(input logic [31:0] x, input int w);
        logic [31:0] max_v;
        max_v = (32'd1 << w) - 32'd1;
        return (x > max_v) ? max_v : x;
    endfunction

endpackage

// File: rtl/lif_neuron_core.sv
// One leaky integrate-and-fire neuron: sum, threshold compare, subtract-reset, saturate.
// Latency: 1 cycle per en step (state/spike registered); optional refractory via LIF_REFRACTORY_EN.
// Backpressure: none; en=0 freezes all state.
module lif_neuron_core
    import lif_pkg::*;
#(
    parameter int W          = LIF_W,
    parameter int LEAK_SHIFT = LIF_LEAK_SHIFT,
    parameter int COUPLE_W   = LIF_COUPLE_W
`ifdef LIF_REFRACTORY_EN
    ,
    parameter int REFRAC     = LIF_REFRAC
`endif
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         cin_spike,
    input  logic [W-1:0] current,
    input  logic [W-1:0] thr,
    output logic [W-1:0] state,
    output logic         spike,
    output logic         fire
);
    localparam int SW = sum_width(W);

    logic [SW-1:0] cur_x;
    logic [SW-1:0] cin_x;
    logic [SW-1:0] leak_x;
    logic [SW-1:0] sum;
    logic [SW-1:0] thr_x;
    logic [W-1:0]  state_nxt;
    logic          gate;

`ifdef LIF_REFRACTORY_EN
    localparam int RW = (REFRAC > 0) ? $clog2(REFRAC + 1) : 1;
    logic [RW-1:0] refr_cnt;

    assign gate = (REFRAC > 0) && (refr_cnt != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            refr_cnt <= '0;
        end else if (en) begin
            if (fire)
                refr_cnt <= RW'(REFRAC);
            else if (gate)
                refr_cnt <= refr_cnt - 1'b1;
        end
    end
`else
    assign gate = 1'b0;
`endif

    // While refractory only the leaked state survives; inputs and coupling are ignored.
    always_comb begin
        cur_x     = gate ? '0 : SW'(current);
        cin_x     = (cin_spike && !gate) ? SW'(COUPLE_W) : '0;
        leak_x    = SW'(state >> LEAK_SHIFT);
        sum       = cur_x + cin_x + leak_x;
        thr_x     = SW'(thr);
        fire      = !gate && (thr != '0) && (sum >= thr_x);
        state_nxt = W'(sat(32'(fire ? (sum - thr_x) : sum), W));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= '0;
            spike <= 1'b0;
        end else if (en) begin
            state <= state_nxt;
            spike <= fire;
        end
    end

endmodule

// File: rtl/lif_layer.sv
// Chain of N LIF neurons; spike_in couples into neuron 0, neuron i-1 couples into neuron i.
// Latency: 1 cycle per en step, one extra step per coupling hop; LIF_REFRACTORY_EN adds refractory.
// Backpressure: none; en=0 holds every register including spike and spike_any.
module lif_layer
    import lif_pkg::*;
#(
    parameter int N          = 4,
    parameter int W          = LIF_W,
    parameter int LEAK_SHIFT = LIF_LEAK_SHIFT,
    parameter int COUPLE_W   = LIF_COUPLE_W
`ifdef LIF_REFRACTORY_EN
    ,
    parameter int REFRAC     = LIF_REFRAC
`endif
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           en,
    input  logic           spike_in,
    input  logic [N*W-1:0] current,
    input  logic [W-1:0]   thr,
    output logic [N*W-1:0] state,
    output logic [N-1:0]   spike,
    output logic           spike_any
);
    logic [N-1:0] cin;
    logic [N-1:0] fire;

    for (genvar i = 0; i < N; i++) begin : g_neuron
        if (i == 0) begin : g_head
            assign cin[i] = spike_in;
        end else begin : g_link
            assign cin[i] = spike[i-1];
        end

        lif_neuron_core #(
            .W          (W),
            .LEAK_SHIFT (LEAK_SHIFT),
            .COUPLE_W   (COUPLE_W)
`ifdef LIF_REFRACTORY_EN
            ,
            .REFRAC     (REFRAC)
`endif
        ) u_core (
            .clk       (clk),
            .rst_n     (rst_n),
            .en        (en),
            .cin_spike (cin[i]),
            .current   (current[i*W +: W]),
            .thr       (thr),
            .state     (state[i*W +: W]),
            .spike     (spike[i]),
            .fire      (fire[i])
        );
    end

    // Registered from the same next-step fire vector so it aligns with spike.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            spike_any <= 1'b0;
        else if (en)
            spike_any <= |fire;
    end

endmodule

// File: tb/tb_lif_layer.sv
// Directed table-driven bench for lif_layer (N=4, W=8), plus async-reset sequence.
module tb_lif_layer;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        spike_in;
    logic [31:0] current;
    logic [7:0]  thr;
    logic [31:0] state;
    logic [3:0]  spike;
    logic        spike_any;

    int n_tests = 0;
    int n_fail  = 0;

    lif_layer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .spike_in  (spike_in),
        .current   (current),
        .thr       (thr),
        .state     (state),
        .spike     (spike),
        .spike_any (spike_any)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          rst;
        bit          en;
        bit          sin;
        logic [31:0] cur;
        logic [7:0]  thr;
        logic [31:0] st;
        logic [3:0]  spk;
        bit          any;
        string       name;
    } vec_t;

    vec_t vq[$];

    task automatic add(input bit rst, input bit en_v, input bit sin, input logic [31:0] cur,
                       input logic [7:0] th, input logic [31:0] st, input logic [3:0] spk,
                       input bit any, input string name);
        vec_t v;
        v.rst = rst; v.en = en_v; v.sin = sin; v.cur = cur; v.thr = th;
        v.st = st; v.spk = spk; v.any = any; v.name = name;
        vq.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%08h), expected %0d (0x%08h)", name, got, got, exp, exp);
        end
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        en       = 1'b0;
        spike_in = 1'b0;
        current  = '0;
        thr      = 8'd200;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; spike_in = 1'b0; current = '0; thr = 8'd200;

        // 1: sub-threshold integration converges to 199
        add(1, 1, 0, 32'd100, 200, 32'd100, 4'b0, 0, "t1_s1");
        add(0, 1, 0, 32'd100, 200, 32'd150, 4'b0, 0, "t1_s2");
        add(0, 1, 0, 32'd100, 200, 32'd175, 4'b0, 0, "t1_s3");
        add(0, 1, 0, 32'd100, 200, 32'd187, 4'b0, 0, "t1_s4");
        add(0, 1, 0, 32'd100, 200, 32'd193, 4'b0, 0, "t1_s5");
        add(0, 1, 0, 32'd100, 200, 32'd196, 4'b0, 0, "t1_s6");
        add(0, 1, 0, 32'd100, 200, 32'd198, 4'b0, 0, "t1_s7");
        add(0, 1, 0, 32'd100, 200, 32'd199, 4'b0, 0, "t1_s8");
        add(0, 1, 0, 32'd100, 200, 32'd199, 4'b0, 0, "t1_s9");

        // per-neuron current lanes
        add(1, 1, 0, {8'd40, 8'd30, 8'd20, 8'd10}, 200, {8'd40, 8'd30, 8'd20, 8'd10}, 4'b0, 0, "idx_s1");
        add(0, 1, 0, {8'd40, 8'd30, 8'd20, 8'd10}, 200, {8'd60, 8'd45, 8'd30, 8'd15}, 4'b0, 0, "idx_s2");

        // 2/3: fire and subtract-reset, coupling into neuron 1
        add(1, 1, 0, 32'd120, 200, 32'd120, 4'b0, 0, "t2_s1");
        add(0, 1, 0, 32'd120, 200, 32'd180, 4'b0, 0, "t2_s2");
        add(0, 1, 0, 32'd120, 200, 32'd10, 4'b0001, 1, "t2_s3");
`ifdef LIF_REFRACTORY_EN
        add(0, 1, 0, 32'd120, 200, {8'd0, 8'd0, 8'd64, 8'd5},   4'b0, 0, "t3_s4");
        add(0, 1, 0, 32'd120, 200, {8'd0, 8'd0, 8'd32, 8'd2},   4'b0, 0, "t3_s5");
        add(0, 1, 0, 32'd120, 200, {8'd0, 8'd0, 8'd16, 8'd121}, 4'b0, 0, "t3_s6");
`else
        add(0, 1, 0, 32'd120, 200, {8'd0, 8'd0, 8'd64, 8'd125}, 4'b0, 0, "t2_s4");
        add(0, 1, 0, 32'd120, 200, {8'd0, 8'd0, 8'd32, 8'd182}, 4'b0, 0, "t2_s5");
        add(0, 1, 0, 32'd120, 200, {8'd0, 8'd0, 8'd16, 8'd11}, 4'b0001, 1, "t2_s6");
`endif

        // 4: strong drive into neuron 0, one-hop coupling delay
        add(1, 1, 0, 32'd255, 200, 32'd55, 4'b0001, 1, "t4_s1");
`ifdef LIF_REFRACTORY_EN
        add(0, 1, 0, 32'd255, 200, {8'd0, 8'd0, 8'd64, 8'd27}, 4'b0, 0, "t4_s2");
        add(0, 1, 0, 32'd255, 200, {8'd0, 8'd0, 8'd32, 8'd13}, 4'b0, 0, "t4_s3");
        add(0, 1, 0, 32'd255, 200, {8'd0, 8'd0, 8'd16, 8'd61}, 4'b0001, 1, "t4_s4");
`else
        add(0, 1, 0, 32'd255, 200, {8'd0, 8'd0, 8'd64, 8'd82}, 4'b0001, 1, "t4_s2");
        add(0, 1, 0, 32'd255, 200, {8'd0, 8'd0, 8'd96, 8'd96}, 4'b0001, 1, "t4_s3");
`endif

        // spike_in couples into neuron 0
        add(1, 1, 1, 32'd150, 200, 32'd14, 4'b0001, 1, "sin_s1");
`ifdef LIF_REFRACTORY_EN
        add(0, 1, 1, 32'd150, 200, {8'd0, 8'd0, 8'd64, 8'd7}, 4'b0, 0, "sin_s2");
`else
        add(0, 1, 1, 32'd150, 200, {8'd0, 8'd0, 8'd64, 8'd21}, 4'b0001, 1, "sin_s2");
`endif

        // 5: thr=0 saturates without firing; thr=255 fires from 382
        add(1, 1, 0, 32'd255, 0,   32'd255, 4'b0, 0, "t5_s1");
        add(0, 1, 0, 32'd255, 0,   32'd255, 4'b0, 0, "t5_s2");
        add(0, 1, 0, 32'd255, 0,   32'd255, 4'b0, 0, "t5_s3");
        add(0, 1, 0, 32'd255, 255, 32'd127, 4'b0001, 1, "t5_thr255");

        // 6: en gating freezes state and held spike
        add(1, 1, 0, 32'd120, 200, 32'd120, 4'b0, 0, "t6_s1");
        add(0, 0, 0, 32'd120, 200, 32'd120, 4'b0, 0, "t6_hold1");
        add(0, 0, 0, 32'd120, 200, 32'd120, 4'b0, 0, "t6_hold2");
        add(0, 1, 0, 32'd120, 200, 32'd180, 4'b0, 0, "t6_s2");
        add(0, 1, 0, 32'd120, 200, 32'd10, 4'b0001, 1, "t6_s3");
        add(0, 0, 0, 32'd120, 200, 32'd10, 4'b0001, 1, "t6_hold_spk");
`ifdef LIF_REFRACTORY_EN
        add(0, 1, 0, 32'd120, 200, {8'd0, 8'd0, 8'd64, 8'd5}, 4'b0, 0, "t6_s4");
`else
        add(0, 1, 0, 32'd120, 200, {8'd0, 8'd0, 8'd64, 8'd125}, 4'b0, 0, "t6_s4");
`endif

        do_reset();
        check("rst_state", state, 32'd0);
        check("rst_spike", {28'd0, spike}, 32'd0);
        check("rst_any", {31'd0, spike_any}, 32'd0);

        foreach (vq[k]) begin
            if (vq[k].rst) do_reset();
            @(negedge clk);
            en       = vq[k].en;
            spike_in = vq[k].sin;
            current  = vq[k].cur;
            thr      = vq[k].thr;
            @(posedge clk);
            #1;
            check({vq[k].name, "_state"}, state, vq[k].st);
            check({vq[k].name, "_spike"}, {28'd0, spike}, {28'd0, vq[k].spk});
            check({vq[k].name, "_any"}, {31'd0, spike_any}, {31'd0, vq[k].any});
        end

        // asynchronous reset in the middle of a run, between clock edges
        do_reset();
        @(negedge clk);
        en = 1'b1; current = 32'd120; thr = 8'd200;
        repeat (3) @(posedge clk);
        #1;
        check("arst_pre_spike", {28'd0, spike}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_state", state, 32'd0);
        check("arst_spike", {28'd0, spike}, 32'd0);
        check("arst_any", {31'd0, spike_any}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("arst_after_state", state, 32'd120);
        check("arst_after_spike", {28'd0, spike}, 32'd0);
        @(posedge clk);
        #1;
        check("arst_after_state2", state, 32'd180);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
